// File: rtl/tank_pkg.sv
// Shared definitions for the tank game blocks.
// Contents: the bullet FSM state enum, the tank bounding-box size, the
// visible screen limits, the off-screen park coordinate used by
// color_mapper, and the game-state encoding for "fight".
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } bullet_state_t;

    // Tank bounding box, measured from its top-left corner
    localparam int TANK_W = 70;
    localparam int TANK_H = 50;

    // Last visible pixel column and row
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;

    // Coordinate that color_mapper never draws
    localparam logic [9:0] PARK_POS = 10'h3FF;

    // Game state in which shooting is allowed
    localparam logic [1:0] FIGHT_STATE = 2'b01;

endpackage

// File: rtl/bullet_ctrl_frame_tick_gen.sv
// frame_tick_gen: turns the slow frame_clk into a one-Clk-cycle tick.
// Ports:
//   clk       - system clock
//   reset_n   - synchronous active-low reset
//   frame_clk - vertical-sync-rate clock, sampled on clk
//   tick      - high for one clk cycle after the sampled frame_clk rises
module frame_tick_gen (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sample;
    logic sample_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample      <= 1'b0;
            sample_prev <= 1'b0;
        end else begin
            sample      <= frame_clk;
            sample_prev <= sample;
        end
    end

    assign tick = sample & ~sample_prev;

endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: launches, flies and scores one tank's bullet.
// A shot leaves the muzzle, moves ballistically once per frame tick, and
// ends in HIT (opponent box reached) or COOLDOWN (left the screen).
// Ports:
//   Clk, Reset_n        - system clock, synchronous active-low reset
//   frame_clk           - vertical-sync-rate clock
//   fire                - shoot request (level)
//   Direction           - bit0: 0 right / 1 left, bit1: 1 steep shot
//   TankX, TankY        - own tank top-left
//   OppX, OppY          - opponent tank top-left
//   currentState        - game state, FIGHT_STATE enables shooting
//   BulletX, BulletY    - bullet centre, PARK_POS when inactive
//   bullet_active       - bullet in FLIGHT or HIT
//   hit                 - one-cycle pulse on reaching the opponent
//   ready               - block is IDLE and can accept a shot
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int BULLET_VX       = 4,
    parameter int LAUNCH_VY_LO    = 6,
    parameter int LAUNCH_VY_HI    = 12,
    parameter int GRAVITY         = 1,
    parameter int HIT_FRAMES      = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [1:0] Direction,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] OppX,
    input  logic [9:0] OppY,
    input  logic [1:0] currentState,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_active,
    output logic       hit,
    output logic       ready
);

    localparam logic signed [10:0] VX_RIGHT  = 11'(BULLET_VX);
    localparam logic signed [10:0] VX_LEFT   = 11'(-BULLET_VX);
    localparam logic signed [10:0] VY_FLAT   = 11'(-LAUNCH_VY_LO);
    localparam logic signed [10:0] VY_STEEP  = 11'(-LAUNCH_VY_HI);
    localparam logic signed [10:0] GRAV      = 11'(GRAVITY);
    localparam logic signed [10:0] MUZZLE_DX = 11'(TANK_W);
    localparam logic signed [10:0] MUZZLE_DY = 11'sd10;
    localparam logic signed [10:0] X_MAX     = 11'(SCREEN_X_MAX);
    localparam logic signed [10:0] Y_MAX     = 11'(SCREEN_Y_MAX);
    localparam logic signed [11:0] BOX_W     = 12'(TANK_W);
    localparam logic signed [11:0] BOX_H     = 12'(TANK_H);
    localparam logic [15:0]        HIT_LAST  = 16'(HIT_FRAMES - 1);
    localparam logic [15:0]        COOL_LAST = 16'(COOLDOWN_FRAMES - 1);

    bullet_state_t state, state_n;

    logic               tick;
    logic               fight;
    logic signed [10:0] pos_x, pos_y, vel_x, vel_y;
    logic signed [10:0] pos_x_n, pos_y_n, vel_x_n, vel_y_n;
    logic signed [10:0] upd_x, upd_y, upd_vy;
    logic signed [11:0] chk_x, chk_y, box_x0, box_y0;
    logic               in_box, off_screen;
    logic [15:0]        cnt, cnt_n;

    logic [9:0]         bullet_x_n, bullet_y_n;
    logic               active_n, hit_n, ready_n;

    frame_tick_gen u_frame_tick_gen (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign fight = (currentState == FIGHT_STATE);

    // Candidate flight step and its end-of-flight tests. The box test is
    // done one bit wider so OppX+70 cannot wrap against an 11-bit X.
    always_comb begin
        upd_x      = pos_x + vel_x;
        upd_y      = pos_y + vel_y;
        upd_vy     = vel_y + GRAV;
        chk_x      = {upd_x[10], upd_x};
        chk_y      = {upd_y[10], upd_y};
        box_x0     = {2'b00, OppX};
        box_y0     = {2'b00, OppY};
        in_box     = (chk_x >= box_x0) && (chk_x <= box_x0 + BOX_W) &&
                     (chk_y >= box_y0) && (chk_y <= box_y0 + BOX_H);
        // Negative Y is above the screen and deliberately not a miss
        off_screen = (upd_x < 11'sd0) || (upd_x > X_MAX) || (upd_y >= Y_MAX);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        if (!fight) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:     if (fire) state_n = FLIGHT;
                FLIGHT:   if (tick) begin
                              if (in_box)          state_n = HIT;
                              else if (off_screen) state_n = COOLDOWN;
                          end
                HIT:      if (tick && cnt == HIT_LAST)  state_n = COOLDOWN;
                COOLDOWN: if (tick && cnt == COOL_LAST) state_n = IDLE;
                default:  state_n = IDLE;
            endcase
        end
    end

    // Datapath next values: muzzle load, ballistic step, frame counters
    always_comb begin
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        vel_x_n = vel_x;
        vel_y_n = vel_y;
        cnt_n   = cnt;
        if (!fight) begin
            pos_x_n = '0;
            pos_y_n = '0;
            vel_x_n = '0;
            vel_y_n = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (fire) begin
                        pos_x_n = Direction[0] ? {1'b0, TankX}
                                               : {1'b0, TankX} + MUZZLE_DX;
                        pos_y_n = {1'b0, TankY} + MUZZLE_DY;
                        vel_x_n = Direction[0] ? VX_LEFT : VX_RIGHT;
                        vel_y_n = Direction[1] ? VY_STEEP : VY_FLAT;
                    end
                end
                FLIGHT: begin
                    cnt_n = '0;
                    if (tick) begin
                        pos_x_n = upd_x;
                        pos_y_n = upd_y;
                        vel_y_n = upd_vy;
                    end
                end
                default: begin
                    if (tick)
                        cnt_n = (state_n != state) ? '0 : cnt + 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pos_x <= '0;
            pos_y <= '0;
            vel_x <= '0;
            vel_y <= '0;
            cnt   <= '0;
        end else begin
            pos_x <= pos_x_n;
            pos_y <= pos_y_n;
            vel_x <= vel_x_n;
            vel_y <= vel_y_n;
            cnt   <= cnt_n;
        end
    end

    // Output logic, evaluated on the next state so the registered outputs
    // line up with the state register rather than lagging it by a cycle.
    always_comb begin
        active_n   = (state_n == FLIGHT) || (state_n == HIT);
        bullet_x_n = active_n ? pos_x_n[9:0] : PARK_POS;
        bullet_y_n = active_n ? pos_y_n[9:0] : PARK_POS;
        hit_n      = (state == FLIGHT) && (state_n == HIT);
        ready_n    = (state_n == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            BulletX       <= PARK_POS;
            BulletY       <= PARK_POS;
            bullet_active <= 1'b0;
            hit           <= 1'b0;
            ready         <= 1'b1;
        end else begin
            BulletX       <= bullet_x_n;
            BulletY       <= bullet_y_n;
            bullet_active <= active_n;
            hit           <= hit_n;
            ready         <= ready_n;
        end
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed testbench for bullet_ctrl with hand-computed expectations.
module tb_bullet_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [1:0] Direction = 2'b00;
    logic [9:0] TankX = '0, TankY = '0, OppX = '0, OppY = '0;
    logic [1:0] currentState = 2'b01;
    logic [9:0] BulletX, BulletY;
    logic       bullet_active, hit, ready;

    int total = 0;
    int bad = 0;
    int hit_cnt = 0;
    int ready_cnt = 0;
    int base;

    bullet_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .fire          (fire),
        .Direction     (Direction),
        .TankX         (TankX),
        .TankY         (TankY),
        .OppX          (OppX),
        .OppY          (OppY),
        .currentState  (currentState),
        .BulletX       (BulletX),
        .BulletY       (BulletY),
        .bullet_active (bullet_active),
        .hit           (hit),
        .ready         (ready)
    );

    always #5 Clk = ~Clk;

    // Count cycles with hit / ready high, sampled just after each edge
    always @(posedge Clk) begin
        #1;
        if (hit)   hit_cnt++;
        if (ready) ready_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One frame_clk pulse; returns on a falling edge after the update landed
    task automatic frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    // Fire for one cycle from IDLE; returns on the falling edge after launch
    task automatic shoot(input logic [1:0] dir, input logic [9:0] tx, input logic [9:0] ty);
        @(negedge Clk);
        Direction = dir;
        TankX = tx;
        TankY = ty;
        fire = 1'b1;
        @(negedge Clk) fire = 1'b0;
    endtask

    initial begin
        // Reset, then idle
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_x", BulletX, 10'h3FF);
        chk("rst_y", BulletY, 10'h3FF);
        chk("rst_ready", ready, 1);
        chk("rst_active", bullet_active, 0);
        chk("rst_hit", hit, 0);

        // Flat shot right from (100,200), opponent far away
        OppX = 10'd900; OppY = 10'd900;
        shoot(2'b00, 10'd100, 10'd200);
        chk("launch_x", BulletX, 170);
        chk("launch_y", BulletY, 210);
        chk("launch_active", bullet_active, 1);
        chk("launch_ready", ready, 0);
        frame_tick();
        chk("t1_x", BulletX, 174);
        chk("t1_y", BulletY, 204);
        frame_tick();
        chk("t2_x", BulletX, 178);
        chk("t2_y", BulletY, 199);
        frame_tick();
        chk("t3_x", BulletX, 182);
        chk("t3_y", BulletY, 195);

        // Leave fight mid-flight
        base = hit_cnt;
        @(negedge Clk) currentState = 2'b00;
        @(negedge Clk);
        chk("abort_ready", ready, 1);
        chk("abort_active", bullet_active, 0);
        chk("abort_x", BulletX, 10'h3FF);
        chk("abort_y", BulletY, 10'h3FF);
        currentState = 2'b01;
        @(negedge Clk);
        chk("abort_nohit", hit_cnt, base);

        // Steep shot left onto the opponent
        OppX = 10'd280; OppY = 10'd60;
        shoot(2'b11, 10'd300, 10'd100);
        chk("hs_launch_x", BulletX, 300);
        chk("hs_launch_y", BulletY, 110);
        base = hit_cnt;
        frame_tick();
        chk("hs_x", BulletX, 296);
        chk("hs_y", BulletY, 98);
        chk("hs_pulse", hit_cnt, base + 1);
        chk("hs_active", bullet_active, 1);
        ticks(7);
        chk("hold_x", BulletX, 296);
        chk("hold_y", BulletY, 98);
        chk("hold_active", bullet_active, 1);
        chk("hold_pulse", hit_cnt, base + 1);
        frame_tick();
        chk("cd_active", bullet_active, 0);
        chk("cd_ready", ready, 0);
        chk("cd_x", BulletX, 10'h3FF);
        ticks(29);
        chk("cd29_ready", ready, 0);
        frame_tick();
        chk("cd30_ready", ready, 1);

        // Miss off the right edge with fire held through the whole shot
        OppX = 10'd0; OppY = 10'd0;
        @(negedge Clk);
        Direction = 2'b00; TankX = 10'd560; TankY = 10'd400;
        fire = 1'b1;
        @(negedge Clk);
        chk("miss_launch_x", BulletX, 630);
        chk("miss_launch_y", BulletY, 410);
        base = hit_cnt;
        ticks(2);
        chk("miss_t2_x", BulletX, 638);
        chk("miss_t2_y", BulletY, 399);
        frame_tick();
        chk("miss_active", bullet_active, 0);
        chk("miss_ready", ready, 0);
        chk("miss_nohit", hit_cnt, base);
        base = ready_cnt;
        ticks(29);
        chk("hold_fire_norelaunch", bullet_active, 0);
        chk("hold_fire_noready", ready_cnt, base);
        frame_tick();
        chk("relaunch_active", bullet_active, 1);
        chk("relaunch_x", BulletX, 630);
        chk("relaunch_ready_cycles", ready_cnt, base + 1);
        fire = 1'b0;

        // Reset mid-flight
        base = hit_cnt;
        @(negedge Clk) Reset_n = 1'b0;
        @(negedge Clk);
        chk("rmid_ready", ready, 1);
        chk("rmid_active", bullet_active, 0);
        chk("rmid_x", BulletX, 10'h3FF);
        chk("rmid_y", BulletY, 10'h3FF);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rmid_nohit", hit_cnt, base);
        chk("rmid_idle", ready, 1);

        // Hit wins over leaving the screen on the same update
        OppX = 10'd640; OppY = 10'd360;
        shoot(2'b00, 10'd560, 10'd400);
        base = hit_cnt;
        ticks(3);
        chk("prio_active", bullet_active, 1);
        chk("prio_x", BulletX, 642);
        chk("prio_y", BulletY, 395);
        chk("prio_pulse", hit_cnt, base + 1);
        @(negedge Clk) currentState = 2'b00;
        @(negedge Clk) currentState = 2'b01;
        @(negedge Clk);
        chk("prio_abort_ready", ready, 1);

        // Above the top of the screen the flight continues
        OppX = 10'd900; OppY = 10'd900;
        shoot(2'b10, 10'd100, 10'd0);
        chk("neg_launch_y", BulletY, 10);
        frame_tick();
        chk("neg_x", BulletX, 174);
        chk("neg_y", BulletY, 10'h3FE);
        chk("neg_active", bullet_active, 1);
        @(negedge Clk) currentState = 2'b00;
        @(negedge Clk);
        chk("neg_abort_active", bullet_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameter BULLET_VX, default 4, horizontal speed in pixels per frame.
REQ-002 Parameter LAUNCH_VY_LO, default 6, upward launch speed for a flat shot, in pixels per frame.
REQ-003 Parameter LAUNCH_VY_HI, default 12, upward launch speed for a steep shot, in pixels per frame.
REQ-004 Parameter GRAVITY, default 1, added to vertical velocity on every frame tick.
REQ-005 Parameter HIT_FRAMES, default 8, number of frames the bullet stays frozen after a hit.
REQ-006 Parameter COOLDOWN_FRAMES, default 30, number of frames after a hit or miss before the next shot.
REQ-007 Ports: Clk in 1, system clock; Reset_n in 1, synchronous active-low reset.
REQ-008 Ports: frame_clk in 1, vertical-sync-rate clock, sampled on Clk.
REQ-009 Ports: fire in 1, shoot request (level); Direction in 2, bit0 0=right/1=left, bit1 1=steep shot.
REQ-010 Ports: TankX, TankY in 10 each, own tank top-left; OppX, OppY in 10 each, opponent tank top-left.
REQ-011 Ports: currentState in 2, game state (2'b01 = fight).
REQ-012 Ports: BulletX, BulletY out 10 each, bullet centre for color_mapper; bullet_active out 1; hit out 1; ready out 1.

Function
REQ-013 A frame tick shall be one Clk cycle, asserted on the cycle after a registered sample of frame_clk goes from 0 to 1.
REQ-014 The FSM states shall be IDLE, FLIGHT, HIT and COOLDOWN.
REQ-015 In IDLE with currentState==2'b01 and fire==1, the block shall go to FLIGHT on the next cycle (one-cycle latency).
REQ-016 On that same FLIGHT entry, position shall load the muzzle: right (TankX+70, TankY+10), left (TankX, TankY+10).
REQ-017 On FLIGHT entry, vx shall load +BULLET_VX (right) or -BULLET_VX (left); vy shall load -LAUNCH_VY_HI (bit1=1) or -LAUNCH_VY_LO (bit1=0).
REQ-018 Position and velocity shall be held internally as 11-bit signed values.
REQ-019 On each frame tick in FLIGHT: X<=X+vx, Y<=Y+vy, vy<=vy+GRAVITY, all updated together from the old values.
REQ-020 After each update, if the new centre lies in OppX..OppX+70 by OppY..OppY+50 (bounds inclusive), the block shall go to HIT and pulse hit for exactly one cycle.
REQ-021 Otherwise, if new X<0, X>639 or Y>=479, the block shall go to COOLDOWN (a miss).
REQ-022 If a hit and an out-of-bounds condition occur on the same update, the hit shall take priority.
REQ-023 A negative Y (above the screen) shall not end the flight.
REQ-024 HIT shall freeze the position for HIT_FRAMES ticks, then go to COOLDOWN.
REQ-025 COOLDOWN shall count COOLDOWN_FRAMES ticks, then go to IDLE.
REQ-026 fire outside IDLE shall be ignored; no request shall be queued.
REQ-027 bullet_active shall be 1 in FLIGHT and HIT, 0 otherwise; ready shall be 1 only in IDLE.
REQ-028 When bullet_active==0, BulletX and BulletY shall be parked at 10'h3FF, off-screen for color_mapper.
REQ-029 When bullet_active==1, BulletX and BulletY shall be the low 10 bits of the internal position.
REQ-030 Whenever currentState!=2'b01, the next state shall be IDLE with counters cleared and outputs parked, from any state.
REQ-031 All outputs shall be registered.

Reset
REQ-032 With Reset_n==0 at a Clk edge, the block shall reset to: state IDLE, position 0, velocity 0, counters 0, frame_clk sample 0.
REQ-033 Output values after reset: BulletX=BulletY=10'h3FF, bullet_active=0, hit=0, ready=1.
REQ-034 Reset asserted mid-flight shall abort the shot with no hit pulse.

Structure
REQ-035 A shared package tank_pkg shall hold the FSM state enum, the tank box constants (70, 50), the screen limits (639, 479), PARK_POS=10'h3FF and the fight state encoding 2'b01.
REQ-036 One sub-module, frame_tick_gen, shall do the frame_clk rising-edge detection.
REQ-037 The top level shall instantiate one bullet_ctrl per tank.

Verification
REQ-038 Reset, then idle: BulletX=BulletY=3FF, ready=1, bullet_active=0.
REQ-039 Tank (100,200), Direction=00, fire: next cycle position (170,210); tick1 (174,204); tick2 (178,199); tick3 (182,195).
REQ-040 Tank (300,100), Direction=11, Opp (280,60): tick1 bullet at (296,98), inside the opponent box; hit pulses 1 cycle, position frozen 8 ticks, then COOLDOWN.
REQ-041 Flat shot right from Tank (560,400): X passes 639 on the 3rd tick -> COOLDOWN, no hit; after 30 ticks ready=1.
REQ-042 Hold fire high through a whole shot: no relaunch until IDLE; relaunch on the first IDLE cycle.
REQ-043 Drop currentState to 00 mid-flight, and separately pull Reset_n low mid-flight: both give IDLE on the next cycle, outputs parked, no hit pulse.
